cpu_mem_responder: RTL

//  Responder end of the CPU instruction and data memory channels: a word-addressed RAM model

---
 rtl/cpu_mem_responder_pkg.sv | 24 ++
 rtl/mem_sram_1rw.sv | 29 ++
 rtl/cpu_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_mem_responder_pkg.sv
// Shared types for the CPU memory responder: FSM states, request kinds
// and the address range helper used by the arbiter.
package cpu_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } req_kind_e;

  localparam int CNT_W = 4;

  // Any byte-address bit above the word-index field puts the access outside the array.
  function automatic logic addrInRange(input logic [31:0] addr, input int addrW);
    return (addr >> (addrW + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_sram_1rw.sv
// Single-port 32-bit word RAM with per-byte write strobes and a registered read port.
// Contents are never reset.
module mem_sram_1rw #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        strb_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Responder for the CPU fetch and data channels: one transaction at a time,
// data requests win over fetches, response after a fixed programmable latency.
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  req_kind_e        kind_q, kind_d, acceptKind;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inRange_q, inRange_d;
  logic             reqReady_q, reqReady_d;
  logic             instValid_q, instValid_d;
  logic             readValid_q, readValid_d;
  logic [31:0]      instruction_q, instruction_d;
  logic [31:0]      readData_q, readData_d;

  logic        dataReq, accept, reqInRange, respTaken, unusedAddrBits;
  logic [31:0] reqAddr, sramRdata, respWord;

  assign dataReq        = MemWrite | MemRead;
  assign accept         = reqReady_q & (dataReq | Inst_Req_Valid);
  assign acceptKind     = MemWrite ? KIND_STORE : (MemRead ? KIND_LOAD : KIND_FETCH);
  assign reqAddr        = dataReq ? Address : PC;
  assign reqInRange     = addrInRange(reqAddr, ADDR_W);
  assign unusedAddrBits = ^reqAddr[1:0];
  assign respTaken      = (kind_q == KIND_FETCH) ? Inst_Ready : Read_data_Ready;
  assign respWord       = inRange_q ? sramRdata : 32'h0;

  // Stores commit and reads launch on the accept edge itself.
  mem_sram_1rw #(.ADDR_W(ADDR_W)) u_sram (
    .clk_i   (clk),
    .we_i    (accept && acceptKind == KIND_STORE && reqInRange),
    .re_i    (accept && acceptKind != KIND_STORE),
    .addr_i  (reqAddr[ADDR_W+1:2]),
    .wdata_i (Write_data),
    .strb_i  (Write_strb),
    .rdata_o (sramRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      kind_q        <= KIND_FETCH;
      cnt_q         <= '0;
      inRange_q     <= 1'b0;
      reqReady_q    <= 1'b0;
      instValid_q   <= 1'b0;
      readValid_q   <= 1'b0;
      instruction_q <= '0;
      readData_q    <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      cnt_q         <= cnt_d;
      inRange_q     <= inRange_d;
      reqReady_q    <= reqReady_d;
      instValid_q   <= instValid_d;
      readValid_q   <= readValid_d;
      instruction_q <= instruction_d;
      readData_q    <= readData_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    inRange_d = inRange_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_WAIT;
          kind_d    = acceptKind;
          cnt_d     = CNT_INIT;
          inRange_d = reqInRange;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = (kind_q == KIND_STORE) ? ST_IDLE : ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (respTaken) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change exactly with the FSM.
  always_comb begin
    reqReady_d    = (state_d == ST_IDLE);
    instValid_d   = (state_d == ST_RESP) && (kind_d == KIND_FETCH);
    readValid_d   = (state_d == ST_RESP) && (kind_d == KIND_LOAD);
    instruction_d = instruction_q;
    readData_d    = readData_q;
    if (state_q == ST_WAIT && state_d == ST_RESP) begin
      if (kind_q == KIND_FETCH) instruction_d = respWord;
      else                      readData_d    = respWord;
    end
  end

  assign Inst_Req_Ready  = reqReady_q;
  assign Mem_Req_Ready   = reqReady_q;
  assign Inst_Valid      = instValid_q;
  assign Read_data_Valid = readValid_q;
  assign Instruction     = instruction_q;
  assign Read_data       = readData_q;

endmodule
